// File: rtl/fault_bist_ctrl.sv
// Exhaustive 4-bit stuck-at BIST controller: applies 16 patterns, compares
// good/faulty outputs, and records detection map, count, first hit and signature.
module fault_bist_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        z_good,
   input  logic        z_fault,
   output logic [3:0]  pat,
   output logic        fault_en,
   output logic        busy,
   output logic        done,
   output logic [4:0]  detect_cnt,
   output logic [15:0] det_map,
   output logic [3:0]  first_det,
   output logic        first_valid,
   output logic [3:0]  sig
);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  pat_q, pat_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] map_q, map_d;
   logic [3:0]  first_q, first_d;
   logic        fv_q, fv_d;
   logic [3:0]  sig_q, sig_d;
   logic        mis;

   assign mis = z_good ^ z_fault;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
         map_q   <= '0;
         first_q <= '0;
         fv_q    <= 1'b0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         map_q   <= map_d;
         first_q <= first_d;
         fv_q    <= fv_d;
         sig_q   <= sig_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      map_d   = map_q;
      first_d = first_q;
      fv_d    = fv_q;
      sig_d   = sig_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = APPLY;
               pat_d   = '0;
               cnt_d   = '0;
               map_d   = '0;
               first_d = '0;
               fv_d    = 1'b0;
               sig_d   = '0;
            end
         end
         APPLY: state_d = SAMPLE;
         SAMPLE: begin
            // Only the closing edge of SAMPLE looks at the circuit outputs
            if (mis) begin
               map_d[pat_q] = 1'b1;
               cnt_d        = cnt_q + 5'd1;
               if (!fv_q) begin
                  first_d = pat_q;
                  fv_d    = 1'b1;
               end
            end
            sig_d = {sig_q[2:0], sig_q[3] ^ sig_q[2] ^ z_fault};
            if (pat_q == 4'hF) begin
               state_d = DONE;
            end else begin
               pat_d   = pat_q + 4'd1;
               state_d = APPLY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == APPLY) || (state_q == SAMPLE);
   assign fault_en    = busy;
   assign done        = (state_q == DONE);
   assign pat         = pat_q;
   assign detect_cnt  = cnt_q;
   assign det_map     = map_q;
   assign first_det   = first_q;
   assign first_valid = fv_q;
   assign sig         = sig_q;

endmodule

// File: tb/tb_fault_bist_ctrl.sv
// Randomized bench for fault_bist_ctrl against a per-run reference model
// built from the good/faulty output tables.
module tb_fault_bist_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        z_good;
   logic        z_fault;
   logic [3:0]  pat;
   logic        fault_en;
   logic        busy;
   logic        done;
   logic [4:0]  detect_cnt;
   logic [15:0] det_map;
   logic [3:0]  first_det;
   logic        first_valid;
   logic [3:0]  sig;

   int n_chk  = 0;
   int n_pass = 0;

   fault_bist_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .z_good      (z_good),
      .z_fault     (z_fault),
      .pat         (pat),
      .fault_en    (fault_en),
      .busy        (busy),
      .done        (done),
      .detect_cnt  (detect_cnt),
      .det_map     (det_map),
      .first_det   (first_det),
      .first_valid (first_valid),
      .sig         (sig)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Full run: table zg/zf gives circuit outputs per pattern index.
   // abort_at >= 0 asserts reset during SAMPLE of that pattern.
   task automatic run(input logic [15:0] zg, input logic [15:0] zf,
                      input bit hold, input int abort_at);
      logic [4:0]  ecnt;
      logic [15:0] emap;
      logic [3:0]  efirst;
      logic        efv;
      logic [3:0]  esig;
      ecnt = 0; emap = 0; efirst = 0; efv = 0; esig = 0;
      for (int i = 0; i < 16; i++) begin
         if (zg[i] != zf[i]) begin
            ecnt++;
            emap[i] = 1'b1;
            if (!efv) begin
               efv    = 1'b1;
               efirst = 4'(i);
            end
         end
         esig = {esig[2:0], esig[3] ^ esig[2] ^ zf[i]};
      end

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("clr_cnt", detect_cnt, 0);
      chk("clr_map", det_map, 0);
      chk("clr_fv",  first_valid, 0);
      chk("clr_sig", sig, 0);
      for (int k = 0; k < 16; k++) begin
         chk("apply_pat",  pat, k);
         chk("apply_busy", {busy, fault_en, done}, 3'b110);
         z_good  = 1'($urandom);
         z_fault = 1'($urandom);
         @(negedge clk);
         chk("samp_pat",  pat, k);
         chk("samp_busy", {busy, fault_en, done}, 3'b110);
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            chk("rst_a", {pat, fault_en, busy, done, detect_cnt}, 0);
            chk("rst_b", {det_map, first_det, first_valid, sig}, 0);
            @(negedge clk);
            rst   = 1'b0;
            start = 1'b0;
            return;
         end
         z_good  = zg[k];
         z_fault = zf[k];
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_flags", {done, busy, fault_en}, 3'b100);
      chk("done_pat",   pat, 15);
      chk("done_cnt",   detect_cnt, ecnt);
      chk("done_map",   det_map, emap);
      chk("done_first", first_det, efirst);
      chk("done_fv",    first_valid, efv);
      chk("done_sig",   sig, esig);
      repeat (2) begin
         z_good  = 1'($urandom);
         z_fault = 1'($urandom);
         @(negedge clk);
      end
      chk("hold_done", {done, busy}, 2'b10);
      chk("hold_res", {detect_cnt, det_map, first_det, first_valid, sig},
          {ecnt, emap, efirst, efv, esig});
   endtask

   initial begin
      logic [15:0] g;
      logic [15:0] f;
      rst = 1'b1; start = 1'b0; z_good = 1'b0; z_fault = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_a", {pat, fault_en, busy, done, detect_cnt}, 0);
      chk("reset_b", {det_map, first_det, first_valid, sig}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle", {busy, done}, 0);

      g = 16'($urandom);
      run(g, g, 1'b0, -1);
      g = 16'($urandom);
      run(g, g ^ 16'h0020, 1'b0, -1);
      run(16'h0000, 16'hFFFF, 1'b0, -1);
      g = 16'($urandom);
      f = 16'($urandom);
      run(g, f, 1'b1, -1);
      g = 16'($urandom);
      f = 16'($urandom);
      run(g, f, 1'b0, -1);
      g = 16'($urandom);
      f = 16'($urandom);
      run(g, f, 1'b0, 7);
      repeat (3) @(negedge clk);
      chk("post_rst_idle", {busy, done, pat}, 0);
      for (int r = 0; r < 4; r++) begin
         g = 16'($urandom);
         f = g ^ (16'($urandom) & 16'($urandom));
         run(g, f, r[0], -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
